// File: rtl/csr_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_ctrl_if
// Description : Request/response handshake bundle between the EX/WB stages
//               and the CSR access controller.
//               master : EX/WB side (drives request, accepts response)
//               slave  : CSR controller side
//   req_valid/req_ready  request handshake
//   req_op[2:0]          [2]=immediate form, [1:0] 00 wr / 01 set / 10 clr
//   req_addr[11:0]       CSR address
//   req_rs1_val[31:0]    rs1 value (register form)
//   req_src_idx[4:0]     rs1 index or zimm
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata[31:0]      old CSR value
//   rsp_illegal          illegal-instruction flag
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_src_idx;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;

  modport master (
    output req_valid, req_op, req_addr, req_rs1_val, req_src_idx, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_rs1_val, req_src_idx, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal
  );
endinterface
`default_nettype wire

// File: rtl/csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_alu / csr_access_ctrl
// Description : Zicsr instruction sequencer against a machine-mode CSR file,
//               including free-running mcycle / minstret counters.
//   clk            clock, all state on rising edge
//   rst_n          synchronous active-low reset
//   bus            request/response handshake (slave modport)
//   instret_inc    one instruction retired this cycle
//   mtvec_o        current mtvec
//   mepc_o         current mepc
//   mstatus_mie_o  current mstatus.MIE
// Revision    : 1.0 - initial release
// ============================================================================

// New-value computation for CSRRW/CSRRS/CSRRC and their immediate forms.
module csr_alu (
  input  logic [1:0]  op,
  input  logic [31:0] old_val,
  input  logic [31:0] operand,
  output logic [31:0] new_val
);
  always_comb begin
    new_val = old_val;
    case (op)
      2'b00:   new_val = operand;
      2'b01:   new_val = old_val | operand;
      2'b10:   new_val = old_val & ~operand;
      default: new_val = old_val;
    endcase
  end
endmodule

module csr_access_ctrl #(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  csr_access_ctrl_if.slave        bus,
  input  logic                    instret_inc,
  output logic [31:0]             mtvec_o,
  output logic [31:0]             mepc_o,
  output logic                    mstatus_mie_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MIE_MASK    = 32'h0000_0888;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state;

  // Latched request
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] operand_q;
  logic        wr_en_q;

  // READ-stage results
  logic [31:0] old_q;
  logic        illegal_q;

  // CSR storage
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  logic [31:0] read_val;
  logic        mapped;
  logic        legal_now;
  logic [31:0] alu_out;
  logic        do_write;

  // Post-mask read view of the currently latched address.
  always_comb begin
    read_val = 32'h0;
    mapped   = 1'b1;
    case (addr_q)
      A_MSTATUS:               read_val = {19'h0, 2'b11, 3'b000, mstatus_mpie,
                                           3'b000, mstatus_mie, 3'b000};
      A_MIE:                   read_val = mie_q;
      A_MTVEC:                 read_val = mtvec_q;
      A_MSCRATCH:              read_val = mscratch_q;
      A_MEPC:                  read_val = mepc_q;
      A_MCAUSE:                read_val = mcause_q;
      A_MCYCLE,   A_CYCLE:     read_val = mcycle_q[31:0];
      A_MCYCLEH,  A_CYCLEH:    read_val = mcycle_q[63:32];
      A_MINSTRET, A_INSTRET:   read_val = minstret_q[31:0];
      A_MINSTRETH, A_INSTRETH: read_val = minstret_q[63:32];
      A_MHARTID:               read_val = HART_ID;
      default:                 mapped   = 1'b0;
    endcase
  end

  // addr[11:10]==2'b11 is the read-only CSR space.
  assign legal_now = (op_q != 2'b11) && mapped &&
                     !(wr_en_q && (addr_q[11:10] == 2'b11));

  csr_alu u_alu (
    .op      (op_q),
    .old_val (old_q),
    .operand (operand_q),
    .new_val (alu_out)
  );

  assign do_write = (state == ST_WRITE) && wr_en_q && !illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      op_q            <= 2'b00;
      addr_q          <= 12'h0;
      operand_q       <= 32'h0;
      wr_en_q         <= 1'b0;
      old_q           <= 32'h0;
      illegal_q       <= 1'b0;
      bus.req_ready   <= 1'b1;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= 32'h0;
      bus.rsp_illegal <= 1'b0;
      mstatus_mie     <= 1'b0;
      mstatus_mpie    <= 1'b0;
      mie_q           <= 32'h0;
      mtvec_q         <= MTVEC_RESET & ALIGN_MASK;
      mscratch_q      <= 32'h0;
      mepc_q          <= 32'h0;
      mcause_q        <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            op_q          <= bus.req_op[1:0];
            addr_q        <= bus.req_addr;
            operand_q     <= bus.req_op[2] ? {27'h0, bus.req_src_idx}
                                           : bus.req_rs1_val;
            // Set/clear with rs1=x0 or zimm=0 is a pure read.
            wr_en_q       <= (bus.req_op[1:0] == 2'b00) ||
                             (bus.req_src_idx != 5'd0);
            bus.req_ready <= 1'b0;
            state         <= ST_READ;
          end
        end
        ST_READ: begin
          old_q     <= read_val;
          illegal_q <= !legal_now;
          state     <= ST_WRITE;
        end
        ST_WRITE: begin
          if (do_write) begin
            case (addr_q)
              A_MSTATUS: begin
                mstatus_mie  <= alu_out[3];
                mstatus_mpie <= alu_out[7];
              end
              A_MIE:      mie_q      <= alu_out & MIE_MASK;
              A_MTVEC:    mtvec_q    <= alu_out & ALIGN_MASK;
              A_MSCRATCH: mscratch_q <= alu_out;
              A_MEPC:     mepc_q     <= alu_out & ALIGN_MASK;
              A_MCAUSE:   mcause_q   <= alu_out;
              default: ;  // counters are written in their own block
            endcase
          end
          bus.rsp_valid   <= 1'b1;
          bus.rsp_rdata   <= illegal_q ? 32'h0 : old_q;
          bus.rsp_illegal <= illegal_q;
          state           <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Counters: a CSR write to a half replaces it and suppresses the increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      if (do_write && addr_q == A_MCYCLE)
        mcycle_q <= {mcycle_q[63:32], alu_out};
      else if (do_write && addr_q == A_MCYCLEH)
        mcycle_q <= {alu_out, mcycle_q[31:0]};
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (do_write && addr_q == A_MINSTRET)
        minstret_q <= {minstret_q[63:32], alu_out};
      else if (do_write && addr_q == A_MINSTRETH)
        minstret_q <= {alu_out, minstret_q[31:0]};
      else if (instret_inc)
        minstret_q <= minstret_q + 64'd1;
    end
  end

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mstatus_mie_o = mstatus_mie;

endmodule
`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_access_ctrl
// Description : Directed self-checking bench for csr_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_access_ctrl;

  localparam logic [31:0] HART_ID     = 32'h0000_0005;
  localparam logic [31:0] MTVEC_RESET = 32'h0000_0101;
  localparam logic [31:0] MTVEC_EFF   = 32'h0000_0100;

  localparam logic [2:0] OP_RW  = 3'b000;
  localparam logic [2:0] OP_RS  = 3'b001;
  localparam logic [2:0] OP_BAD = 3'b011;
  localparam logic [2:0] OP_RSI = 3'b101;
  localparam logic [2:0] OP_RCI = 3'b110;

  logic        clk;
  logic        rst_n;
  logic        instret_inc;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mstatus_mie;

  int n_checks;
  int n_errors;

  csr_access_ctrl_if bus ();

  csr_access_ctrl #(
    .HART_ID     (HART_ID),
    .MTVEC_RESET (MTVEC_RESET)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .instret_inc   (instret_inc),
    .mtvec_o       (mtvec),
    .mepc_o        (mepc),
    .mstatus_mie_o (mstatus_mie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request; holds rsp_ready low for 'hold' cycles once the
  // response appears, checking it stays at hold_exp with req_ready low.
  task automatic do_req(input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] idx,
                        input int hold, input logic [31:0] hold_exp,
                        output logic [31:0] rdata, output logic ill,
                        output int lat);
    int n;
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_addr    = addr;
    bus.req_rs1_val = rs1;
    bus.req_src_idx = idx;
    bus.rsp_ready   = (hold == 0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n   = 0;
    lat = 0;
    while (lat == 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) lat = n;
    end
    if (lat == 0) begin
      check("rsp_timeout", {31'h0, bus.rsp_valid}, 32'h1);
      rdata = 32'h0;
      ill   = 1'b0;
    end else begin
      rdata = bus.rsp_rdata;
      ill   = bus.rsp_illegal;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", {31'h0, bus.rsp_valid}, 32'h1);
        check("hold_rdata", bus.rsp_rdata, hold_exp);
        check("hold_ready", {31'h0, bus.req_ready}, 32'h0);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        il;
  int          lat;
  logic [31:0] c0;

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    instret_inc     = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_op      = 3'b000;
    bus.req_addr    = 12'h0;
    bus.req_rs1_val = 32'h0;
    bus.req_src_idx = 5'd0;
    bus.rsp_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_illegal", {31'h0, bus.rsp_illegal}, 32'h0);
    check("rst_mtvec", mtvec, MTVEC_EFF);
    check("rst_mepc", mepc, 32'h0);
    check("rst_mie", {31'h0, mstatus_mie}, 32'h0);

    // mscratch write / read-back, latency
    do_req(OP_RW, 12'h340, 32'hDEAD_BEEF, 5'd5, 0, 32'h0, rd, il, lat);
    check("mscratch_w_rdata", rd, 32'h0);
    check("mscratch_w_ill", {31'h0, il}, 32'h0);
    check("latency", lat, 32'd3);
    do_req(OP_RS, 12'h340, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("mscratch_rd", rd, 32'hDEAD_BEEF);

    // mstatus: set with rs1=x0 never writes; CSRRSI zimm=8 sets MIE
    do_req(OP_RS, 12'h300, 32'hFFFF_FFFF, 5'd0, 0, 32'h0, rd, il, lat);
    check("mstatus_rd0", rd, 32'h0000_1800);
    check("mstatus_mie0", {31'h0, mstatus_mie}, 32'h0);
    do_req(OP_RSI, 12'h300, 32'h0, 5'd8, 0, 32'h0, rd, il, lat);
    check("mstatus_rsi_old", rd, 32'h0000_1800);
    check("mstatus_mie1", {31'h0, mstatus_mie}, 32'h1);
    do_req(OP_RS, 12'h300, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("mstatus_rd1", rd, 32'h0000_1808);

    // mie mask and clear-immediate
    do_req(OP_RW, 12'h304, 32'hFFFF_FFFF, 5'd1, 0, 32'h0, rd, il, lat);
    check("mie_w_old", rd, 32'h0);
    do_req(OP_RCI, 12'h304, 32'h0, 5'd8, 0, 32'h0, rd, il, lat);
    check("mie_masked", rd, 32'h0000_0888);
    do_req(OP_RS, 12'h304, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("mie_cleared", rd, 32'h0000_0880);

    // Read-only space
    do_req(OP_RW, 12'hC00, 32'h1234_0000, 5'd3, 0, 32'h0, rd, il, lat);
    check("cycle_w_ill", {31'h0, il}, 32'h1);
    check("cycle_w_rdata", rd, 32'h0);
    do_req(OP_RS, 12'hC00, 32'h0, 5'd0, 0, 32'h0, c0, il, lat);
    check("cycle_r_ill", {31'h0, il}, 32'h0);
    do_req(OP_RS, 12'hC00, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("cycle_delta", rd, c0 + 32'd4);
    do_req(OP_RS, 12'hF14, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("mhartid", rd, HART_ID);
    do_req(OP_RSI, 12'hF14, 32'h0, 5'd1, 0, 32'h0, rd, il, lat);
    check("mhartid_w_ill", {31'h0, il}, 32'h1);
    do_req(OP_BAD, 12'h340, 32'h0, 5'd1, 0, 32'h0, rd, il, lat);
    check("op11_ill", {31'h0, il}, 32'h1);
    check("op11_rdata", rd, 32'h0);

    // mcycle wrap
    do_req(OP_RW, 12'hB80, 32'hFFFF_FFFF, 5'd1, 0, 32'h0, rd, il, lat);
    do_req(OP_RW, 12'hB00, 32'hFFFF_FFFF, 5'd1, 0, 32'h0, rd, il, lat);
    do_req(OP_RS, 12'hB80, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("mcycleh_wrap", rd, 32'h0);
    do_req(OP_RS, 12'hB00, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("mcycle_wrap", rd, 32'd5);

    // minstret write wins over a coincident increment
    instret_inc = 1'b1;
    do_req(OP_RW, 12'hB02, 32'h1234_5678, 5'd2, 0, 32'h0, rd, il, lat);
    instret_inc = 1'b0;
    do_req(OP_RS, 12'hB02, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("minstret", rd, 32'h1234_5679);
    do_req(OP_RS, 12'hB82, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("minstreth", rd, 32'h0);

    // Response back-pressure, unmapped address
    do_req(OP_RS, 12'h340, 32'h0, 5'd0, 5, 32'hDEAD_BEEF, rd, il, lat);
    check("hold_final", rd, 32'hDEAD_BEEF);
    do_req(OP_RS, 12'h7C0, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("unmapped_ill", {31'h0, il}, 32'h1);
    check("unmapped_rdata", rd, 32'h0);

    // Alignment masks on mtvec / mepc
    do_req(OP_RW, 12'h305, 32'h0000_1003, 5'd1, 0, 32'h0, rd, il, lat);
    check("mtvec_old", rd, MTVEC_EFF);
    check("mtvec_o", mtvec, 32'h0000_1000);
    do_req(OP_RW, 12'h341, 32'h8000_0007, 5'd1, 0, 32'h0, rd, il, lat);
    check("mepc_o", mepc, 32'h8000_0004);

    // Reset in WRITE: the mtvec write is dropped
    bus.req_valid   = 1'b1;
    bus.req_op      = OP_RW;
    bus.req_addr    = 12'h305;
    bus.req_rs1_val = 32'h0000_2000;
    bus.req_src_idx = 5'd1;
    @(posedge clk);          // accept -> READ
    #1 bus.req_valid = 1'b0;
    @(posedge clk);          // READ -> WRITE
    #1 rst_n = 1'b0;
    @(posedge clk);          // reset wins over the write
    #1;
    check("rst_mid_mtvec", mtvec, MTVEC_EFF);
    check("rst_mid_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_mid_ready", {31'h0, bus.req_ready}, 32'h1);
    rst_n = 1'b1;
    do_req(OP_RS, 12'h340, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("rst_mscratch", rd, 32'h0);
    do_req(OP_RS, 12'h305, 32'h0, 5'd0, 0, 32'h0, rd, il, lat);
    check("rst_mtvec_rd", rd, MTVEC_EFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
